// File: rtl/sd_pkg.sv
// Shared constants and the CRC7 step function for the SD CMD line.
// Used by the response receiver; the command transmitter can reuse it.
package sd_pkg;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_START = 2'd1;
    localparam logic [1:0] RECEIVE    = 2'd2;

    localparam int SHORT_LEN = 48;
    localparam int LONG_LEN  = 136;

    // x^7 + x^3 + 1 without the implicit x^7 term
    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
        logic inv;
        inv = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (inv ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_sync.sv
// Bit-serial CRC7 accumulator with synchronous clear.
// CLR wins over EN so a new frame always starts from zero.
module sd_crc7_sync
    import sd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_crc <= 7'h00;
        else if (i_clr)
            r_crc <= 7'h00;
        else if (i_en)
            r_crc <= crc7_next(r_crc, i_bit);
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a 48/136-bit
// response, checks CRC7 and framing, and reports the result with a DONE pulse.
module sd_cmd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX = 64,
    parameter int CNT_W   = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_biten,
    input  logic         i_cmdin,
    input  logic         i_start,
    input  logic         i_long,
    input  logic         i_chkcrc,
    input  logic         i_abort,
    output logic         o_busy,
    output logic         o_done,
    output logic [5:0]   o_resp_index,
    output logic [127:0] o_resp_data,
    output logic         o_crc_err,
    output logic         o_tx_err,
    output logic         o_end_err,
    output logic         o_timeout
);

    localparam logic [CNT_W-1:0] P_SHORT = CNT_W'(SHORT_LEN - 2);
    localparam logic [CNT_W-1:0] P_LONG  = CNT_W'(LONG_LEN - 2);
    localparam logic [CNT_W-1:0] P_TMO   = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] P_133   = CNT_W'(133);
    localparam logic [CNT_W-1:0] P_128   = CNT_W'(128);
    localparam logic [CNT_W-1:0] P_127   = CNT_W'(127);
    localparam logic [CNT_W-1:0] P_45    = CNT_W'(45);
    localparam logic [CNT_W-1:0] P_40    = CNT_W'(40);
    localparam logic [CNT_W-1:0] P_39    = CNT_W'(39);
    localparam logic [CNT_W-1:0] P_8     = CNT_W'(8);
    localparam logic [CNT_W-1:0] P_7     = CNT_W'(7);
    localparam logic [CNT_W-1:0] P_1     = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;     // timeout count in WAIT_START, bit position p in RECEIVE
    logic             r_long;
    logic             r_chkcrc;
    logic [6:0]       r_rxcrc;
    logic             r_done;
    logic [5:0]       r_index;
    logic [127:0]     r_data;
    logic             r_crc_err;
    logic             r_tx_err;
    logic             r_end_err;
    logic             r_timeout;

    logic             w_sample;
    logic             w_start;
    logic             w_crc_en;
    logic [6:0]       w_crc;

    assign w_sample = i_biten & ~i_abort;
    assign w_start  = i_start & ~i_abort & (r_state == IDLE);

    // Short frames cover start bit through arg; long frames only the CID/CSD body.
    always_comb begin
        w_crc_en = 1'b0;
        if (w_sample) begin
            if (r_state == WAIT_START)
                w_crc_en = ~i_cmdin & ~r_long;
            else if (r_state == RECEIVE)
                w_crc_en = (r_cnt >= P_8) & (~r_long | (r_cnt <= P_127));
        end
    end

    sd_crc7_sync u_crc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (w_crc_en),
        .i_clr     (w_start),
        .i_bit     (i_cmdin),
        .o_crc     (w_crc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_long    <= 1'b0;
            r_chkcrc  <= 1'b0;
            r_rxcrc   <= 7'h00;
            r_done    <= 1'b0;
            r_index   <= 6'h00;
            r_data    <= '0;
            r_crc_err <= 1'b0;
            r_tx_err  <= 1'b0;
            r_end_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_long    <= i_long;
                            r_chkcrc  <= i_chkcrc;
                            r_cnt     <= '0;
                            r_rxcrc   <= 7'h00;
                            r_index   <= 6'h00;
                            r_data    <= '0;
                            r_crc_err <= 1'b0;
                            r_tx_err  <= 1'b0;
                            r_end_err <= 1'b0;
                            r_timeout <= 1'b0;
                            r_state   <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (i_biten) begin
                            if (i_cmdin) begin
                                if (r_cnt == P_TMO) begin
                                    r_timeout <= 1'b1;
                                    r_done    <= 1'b1;
                                    r_state   <= IDLE;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end else begin
                                r_cnt   <= r_long ? P_LONG : P_SHORT;
                                r_state <= RECEIVE;
                            end
                        end
                    end
                    RECEIVE: begin
                        if (i_biten) begin
                            if (r_cnt == (r_long ? P_LONG : P_SHORT))
                                r_tx_err <= i_cmdin;
                            if (r_long) begin
                                if (r_cnt <= P_133 && r_cnt >= P_128)
                                    r_index <= {r_index[4:0], i_cmdin};
                                if (r_cnt <= P_127 && r_cnt >= P_1)
                                    r_data[127:1] <= {r_data[126:1], i_cmdin};
                            end else begin
                                if (r_cnt <= P_45 && r_cnt >= P_40)
                                    r_index <= {r_index[4:0], i_cmdin};
                                if (r_cnt <= P_39 && r_cnt >= P_8)
                                    r_data[31:0] <= {r_data[30:0], i_cmdin};
                            end
                            if (r_cnt <= P_7 && r_cnt >= P_1)
                                r_rxcrc <= {r_rxcrc[5:0], i_cmdin};
                            if (r_cnt == '0) begin
                                r_end_err <= ~i_cmdin;
                                r_crc_err <= r_chkcrc & (w_crc != r_rxcrc);
                                r_done    <= 1'b1;
                                r_state   <= IDLE;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_busy       = (r_state != IDLE);
    assign o_done       = r_done;
    assign o_resp_index = r_index;
    assign o_resp_data  = r_data;
    assign o_crc_err    = r_crc_err;
    assign o_tx_err     = r_tx_err;
    assign o_end_err    = r_end_err;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Randomized self-checking bench for sd_cmd_resp_rx: frames are built from fields,
// expected results come from the frame bits and a long-division CRC7 model.
module tb_sd_cmd_resp_rx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         biten = 1'b0;
    logic         cmdin = 1'b1;
    logic         start = 1'b0;
    logic         lng = 1'b0;
    logic         chk = 1'b0;
    logic         abort = 1'b0;
    logic         o_busy, o_done, o_crc_err, o_tx_err, o_end_err, o_timeout;
    logic [5:0]   o_resp_index;
    logic [127:0] o_resp_data;

    int n_pass = 0;
    int n_tot  = 0;

    // expected DUT state after the next active edge, plus expected result fields
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [5:0]   x_idx = '0;
    logic [127:0] x_data = '0;
    logic         x_crc = 1'b0, x_tx = 1'b0, x_end = 1'b0, x_tmo = 1'b0;

    always #5 clk = ~clk;

    sd_cmd_resp_rx #(.NCR_MAX(64), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_biten      (biten),
        .i_cmdin      (cmdin),
        .i_start      (start),
        .i_long       (lng),
        .i_chkcrc     (chk),
        .i_abort      (abort),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_resp_index (o_resp_index),
        .o_resp_data  (o_resp_data),
        .o_crc_err    (o_crc_err),
        .o_tx_err     (o_tx_err),
        .o_end_err    (o_end_err),
        .o_timeout    (o_timeout)
    );

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // remainder of M(x)*x^7 mod (x^7+x^3+1), message f[hi] first
    function automatic logic [6:0] crc_div(input logic [135:0] f, input int hi, input int lo);
        logic [142:0] m;
        int n;
        m = '0;
        n = hi - lo + 1;
        for (int k = 0; k < n; k++) m[k+7] = f[lo+k];
        for (int i = n + 6; i >= 7; i--)
            if (m[i]) m[i-:8] = m[i-:8] ^ 8'h89;
        return m[6:0];
    endfunction

    function automatic logic [135:0] mk_short(input logic tx, input logic [5:0] idx,
                                              input logic [31:0] arg, input logic endb);
        logic [135:0] f;
        f = {88'b0, 1'b0, tx, idx, arg, 7'h00, endb};
        f[7:1] = crc_div(f, 47, 8);
        return f;
    endfunction

    // per-cycle compare: expectations are captured at the edge, outputs checked mid-cycle
    initial begin
        logic e_busy, e_done;
        forever begin
            @(posedge clk);
            e_busy = m_busy;
            e_done = m_done;
            @(negedge clk);
            chk_b("busy", o_busy, e_busy);
            chk_b("done", o_done, e_done);
            if (e_done) begin
                chk_v("index", 128'(o_resp_index), 128'(x_idx));
                chk_v("data", o_resp_data, x_data);
                chk_b("crc_err", o_crc_err, x_crc);
                chk_b("tx_err", o_tx_err, x_tx);
                chk_b("end_err", o_end_err, x_end);
                chk_b("timeout", o_timeout, x_tmo);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            biten = 1'($urandom);
            cmdin = 1'b1;
            cyc();
        end
        biten = 1'b0;
    endtask

    task automatic start_rx(input logic l, input logic c);
        start = 1'b1; lng = l; chk = c;
        biten = 1'b1; cmdin = 1'b0;       // must not be taken as a start bit
        m_busy = 1'b1; m_done = 1'b0;
        cyc();
        start = 1'b0; biten = 1'b0;
        lng = 1'($urandom); chk = 1'($urandom);
    endtask

    task automatic strobe(input logic b, input logic last);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            biten = 1'b0;
            cmdin = 1'($urandom);
            start = ($urandom_range(0, 5) == 0);
            cyc();
        end
        biten = 1'b1;
        cmdin = b;
        start = ($urandom_range(0, 5) == 0);
        if (last) begin
            m_done = 1'b1;
            m_busy = 1'b0;
        end
        cyc();
        biten = 1'b0; start = 1'b0; m_done = 1'b0;
    endtask

    task automatic run(input logic [135:0] f, input logic l, input logic c, input int pre);
        int len;
        len    = l ? 136 : 48;
        x_idx  = l ? f[133:128] : f[45:40];
        x_data = l ? {f[127:1], 1'b0} : {96'b0, f[39:8]};
        x_tx   = f[len-2];
        x_end  = ~f[0];
        x_crc  = c & (crc_div(f, l ? 127 : 47, 8) != f[7:1]);
        x_tmo  = 1'b0;
        start_rx(l, c);
        repeat (pre) strobe(1'b1, 1'b0);
        for (int p = len - 1; p >= 0; p--) strobe(f[p], p == 0);
        idle(3);
    endtask

    // drive a frame up to bit p=20, then hit it with ABORT (kind=0) or reset (kind=1)
    task automatic cut_at_20(input logic [135:0] f, input logic kind);
        start_rx(1'b0, 1'b1);
        for (int p = 47; p > 20; p--) strobe(f[p], 1'b0);
        biten = 1'b1; cmdin = f[20];
        if (kind) rst_n = 1'b0; else abort = 1'b1;
        m_busy = 1'b0; m_done = 1'b0;
        cyc();
        biten = 1'b0; abort = 1'b0; rst_n = 1'b1;
        idle(6);
    endtask

    initial begin
        logic [135:0] f;
        logic [135:0] r2;
        logic         l, c;

        repeat (3) cyc();
        chk_v("rst_data", o_resp_data, 128'h0);
        chk_v("rst_index", 128'(o_resp_index), 128'h0);
        chk_b("rst_flags", o_crc_err | o_tx_err | o_end_err | o_timeout, 1'b0);
        rst_n = 1'b1;
        idle(2);

        chk_v("model_crc_cmd0", 128'(crc_div({88'b0, 48'h400000000095}, 47, 8)), 128'h4A);
        chk_v("model_crc_cmd8", 128'(crc_div({88'b0, 48'h48000001AA87}, 47, 8)), 128'h43);

        run({88'b0, 48'h400000000095}, 1'b0, 1'b1, 0);
        chk_v("cmd0_index", 128'(o_resp_index), 128'h0);
        chk_v("cmd0_data", o_resp_data, 128'h0);
        chk_b("cmd0_tx", o_tx_err, 1'b1);
        chk_b("cmd0_crc", o_crc_err, 1'b0);
        chk_b("cmd0_end", o_end_err, 1'b0);

        run({88'b0, 48'h48000001AA87}, 1'b0, 1'b1, 5);
        chk_v("cmd8_index", 128'(o_resp_index), 128'h8);
        chk_v("cmd8_data", o_resp_data, 128'h1AA);
        chk_b("cmd8_crc", o_crc_err, 1'b0);

        f = mk_short(1'b0, 6'd17, 32'h00000900, 1'b1);
        run(f, 1'b0, 1'b1, 2);
        chk_b("r1_flags", o_crc_err | o_tx_err | o_end_err | o_timeout, 1'b0);
        f[8] = ~f[8];
        run(f, 1'b0, 1'b1, 0);
        chk_b("r1_flip_crc", o_crc_err, 1'b1);
        chk_b("r1_flip_other", o_tx_err | o_end_err | o_timeout, 1'b0);

        run({88'b0, 1'b0, 1'b0, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}, 1'b0, 1'b0, 1);
        chk_v("r3_index", 128'(o_resp_index), 128'h3F);
        chk_v("r3_data", o_resp_data, 128'h80FF8000);
        chk_b("r3_crc", o_crc_err, 1'b0);

        r2 = {1'b0, 1'b0, 6'h3F, 120'h035344534430_3132_8012345678_0133, 7'h00, 1'b1};
        r2[7:1] = crc_div(r2, 127, 8);
        run(r2, 1'b1, 1'b1, 3);
        chk_v("r2_data_hi", {o_resp_data[127:8], 8'h00},
              {120'h035344534430_3132_8012345678_0133, 8'h00});
        chk_b("r2_crc", o_crc_err, 1'b0);
        r2[0] = 1'b0;
        run(r2, 1'b1, 1'b1, 0);
        chk_b("r2_end", o_end_err, 1'b1);

        // timeout: 64 high samples, DONE exactly once
        x_idx = '0; x_data = '0; x_crc = 1'b0; x_tx = 1'b0; x_end = 1'b0; x_tmo = 1'b1;
        start_rx(1'b0, 1'b1);
        for (int i = 1; i <= 64; i++) strobe(1'b1, i == 64);
        idle(10);
        chk_b("tmo_flag", o_timeout, 1'b1);

        f = mk_short(1'b0, 6'd17, 32'h00000900, 1'b1);
        cut_at_20(f, 1'b0);
        run(f, 1'b0, 1'b1, 0);
        chk_b("post_abort_crc", o_crc_err, 1'b0);
        cut_at_20(f, 1'b1);
        chk_v("mid_rst_data", o_resp_data, 128'h0);
        chk_b("mid_rst_tx", o_tx_err, 1'b0);
        run(f, 1'b0, 1'b1, 4);
        chk_v("post_rst_data", o_resp_data, 128'h900);

        for (int t = 0; t < 10; t++) begin
            l = 1'($urandom);
            c = 1'($urandom);
            f = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            if (l) begin
                f[135] = 1'b0;
                if ($urandom_range(0, 2) != 0) f[7:1] = crc_div(f, 127, 8);
            end else begin
                f = {88'b0, 1'b0, f[46:0]};
                if ($urandom_range(0, 2) != 0) f[7:1] = crc_div(f, 47, 8);
            end
            run(f, l, c, $urandom_range(0, 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
